// File: rtl/hall_commutator.sv
`default_nettype none
// ============================================================================
// Module   : hall_commutator
// Brief    : Hall-sensor six-step commutator with glitch filter, step checking
//            and hall-period measurement.
// Revision : 1.0
// ============================================================================
module hall_commutator #(
  parameter int FILTER_LEN = 4,
  parameter int PERIOD_W   = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [2:0]          hall,
  input  logic                dir,
  input  logic                fault_clr,
  output logic [2:0]          h_phase,
  output logic [2:0]          off_phase,
  output logic                fault,
  output logic                step_err,
  output logic [PERIOD_W-1:0] hall_period,
  output logic                period_valid,
  output logic                stalled,
  output logic                rot_dir
);

  localparam logic [7:0]          C_FLEN = 8'(FILTER_LEN);
  localparam logic [PERIOD_W-1:0] C_PMAX = '1;

  logic [2:0]          sync1_q, sync2_q, samp_q;
  logic [2:0]          hall_f_q, hall_f_d;
  logic [7:0]          fcnt_q, fcnt_d;
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d, pinc;
  logic [PERIOD_W-1:0] hall_period_q, hall_period_d;
  logic [2:0]          h_phase_q, h_phase_d, off_phase_q, off_phase_d;
  logic [2:0]          high_w, off_w;
  logic                fault_q, fault_d;
  logic                step_err_q, step_err_d;
  logic                period_valid_q, period_valid_d;
  logic                stalled_q, stalled_d;
  logic                rot_dir_q, rot_dir_d;
  logic                vv_change, illegal;
  logic [3:0]          idx_sum, delta;

  function automatic logic [2:0] seq_idx(input logic [2:0] h);
    case (h)
      3'b101:  seq_idx = 3'd0;
      3'b100:  seq_idx = 3'd1;
      3'b110:  seq_idx = 3'd2;
      3'b010:  seq_idx = 3'd3;
      3'b011:  seq_idx = 3'd4;
      3'b001:  seq_idx = 3'd5;
      default: seq_idx = 3'd0;
    endcase
  endfunction

  function automatic logic is_valid(input logic [2:0] h);
    is_valid = (h != 3'b000) && (h != 3'b111);
  endfunction

  always_comb begin
    // Run length of the current synchronised sample, held once it reaches FILTER_LEN
    fcnt_d = 8'd1;
    if (sync2_q == samp_q)
      fcnt_d = (fcnt_q >= C_FLEN) ? fcnt_q : fcnt_q + 8'd1;
    hall_f_d = (fcnt_d == C_FLEN) ? sync2_q : hall_f_q;

    vv_change = (hall_f_d != hall_f_q) && is_valid(hall_f_q) && is_valid(hall_f_d);
    idx_sum   = {1'b0, seq_idx(hall_f_d)} + 4'd6 - {1'b0, seq_idx(hall_f_q)};
    delta     = (idx_sum >= 4'd6) ? idx_sum - 4'd6 : idx_sum;
    illegal   = vv_change && (delta != 4'd1) && (delta != 4'd5);

    rot_dir_d = rot_dir_q;
    if (vv_change && delta == 4'd1) rot_dir_d = 1'b0;
    if (vv_change && delta == 4'd5) rot_dir_d = 1'b1;

    step_err_d = step_err_q;
    if (illegal)        step_err_d = 1'b1;
    else if (fault_clr) step_err_d = 1'b0;

    pinc           = (pcnt_q == C_PMAX) ? C_PMAX : pcnt_q + 1'b1;
    pcnt_d         = vv_change ? '0 : pinc;
    hall_period_d  = vv_change ? pinc : hall_period_q;
    period_valid_d = vv_change;
    stalled_d      = stalled_q;
    if (vv_change)           stalled_d = 1'b0;
    else if (pinc == C_PMAX) stalled_d = 1'b1;

    high_w  = 3'b000;
    off_w   = 3'b111;
    fault_d = 1'b0;
    case (hall_f_q)
      3'b101:  begin high_w = 3'b100; off_w = 3'b001; end
      3'b100:  begin high_w = 3'b100; off_w = 3'b010; end
      3'b110:  begin high_w = 3'b010; off_w = 3'b100; end
      3'b010:  begin high_w = 3'b010; off_w = 3'b001; end
      3'b011:  begin high_w = 3'b001; off_w = 3'b010; end
      3'b001:  begin high_w = 3'b001; off_w = 3'b100; end
      default: fault_d = 1'b1;
    endcase
    // Reverse drive swaps high and low; the fault pattern maps onto itself
    h_phase_d   = dir ? ~(high_w | off_w) : high_w;
    off_phase_d = off_w;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q        <= 3'b000;
      sync2_q        <= 3'b000;
      samp_q         <= 3'b000;
      fcnt_q         <= 8'd0;
      hall_f_q       <= 3'b000;
      pcnt_q         <= '0;
      hall_period_q  <= '0;
      period_valid_q <= 1'b0;
      stalled_q      <= 1'b0;
      step_err_q     <= 1'b0;
      rot_dir_q      <= 1'b0;
      h_phase_q      <= 3'b000;
      off_phase_q    <= 3'b111;
      fault_q        <= 1'b1;
    end else begin
      sync1_q        <= hall;
      sync2_q        <= sync1_q;
      samp_q         <= sync2_q;
      fcnt_q         <= fcnt_d;
      hall_f_q       <= hall_f_d;
      pcnt_q         <= pcnt_d;
      hall_period_q  <= hall_period_d;
      period_valid_q <= period_valid_d;
      stalled_q      <= stalled_d;
      step_err_q     <= step_err_d;
      rot_dir_q      <= rot_dir_d;
      h_phase_q      <= h_phase_d;
      off_phase_q    <= off_phase_d;
      fault_q        <= fault_d;
    end
  end

  assign h_phase      = h_phase_q;
  assign off_phase    = off_phase_q;
  assign fault        = fault_q;
  assign step_err     = step_err_q;
  assign hall_period  = hall_period_q;
  assign period_valid = period_valid_q;
  assign stalled      = stalled_q;
  assign rot_dir      = rot_dir_q;

endmodule
`default_nettype wire

// File: tb/tb_hall_commutator.sv
`default_nettype none
// ============================================================================
// Module   : tb_hall_commutator
// Brief    : Directed bench for hall_commutator with a cycle-level reference model.
// Revision : 1.0
// ============================================================================
module tb_hall_commutator;

  localparam int FL   = 4;
  localparam int PW   = 8;
  localparam int PMAX = 255;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    hall = 3'b101;
  logic          dir = 1'b0;
  logic          fault_clr = 1'b0;
  logic [2:0]    h_phase, off_phase;
  logic          fault, step_err, period_valid, stalled, rot_dir;
  logic [PW-1:0] hall_period;

  hall_commutator #(.FILTER_LEN(FL), .PERIOD_W(PW)) dut (
    .clock(clock), .reset(reset), .hall(hall), .dir(dir), .fault_clr(fault_clr),
    .h_phase(h_phase), .off_phase(off_phase), .fault(fault), .step_err(step_err),
    .hall_period(hall_period), .period_valid(period_valid), .stalled(stalled),
    .rot_dir(rot_dir)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int pv_seen = 0;

  function automatic int idx_of(input logic [2:0] h);
    case (h)
      3'b101:  return 0;
      3'b100:  return 1;
      3'b110:  return 2;
      3'b010:  return 3;
      3'b011:  return 4;
      3'b001:  return 5;
      default: return -1;
    endcase
  endfunction

  function automatic logic [5:0] drive_tab(input logic [2:0] h);
    case (h)
      3'b101:  return {3'b100, 3'b001};
      3'b100:  return {3'b100, 3'b010};
      3'b110:  return {3'b010, 3'b100};
      3'b010:  return {3'b010, 3'b001};
      3'b011:  return {3'b001, 3'b010};
      3'b001:  return {3'b001, 3'b100};
      default: return {3'b000, 3'b111};
    endcase
  endfunction

  // Reference model: expected outputs after each rising edge
  int            e = 0;
  int            base = 0;
  logic [2:0]    raw_q[$];
  logic [2:0]    smp_q[$];
  logic [2:0]    mf = 3'b000;
  logic [2:0]    exp_h = 3'b000, exp_off = 3'b111;
  logic          exp_fault = 1'b1, exp_serr = 1'b0, exp_pv = 1'b0;
  logic          exp_stall = 1'b0, exp_rot = 1'b0;
  logic [PW-1:0] exp_per = '0;

  always @(posedge clock) begin
    logic [5:0] tab;
    logic [2:0] s, nf;
    logic       stable, bad;
    int         oi, ni, d;
    e++;
    if (reset) begin
      raw_q.delete();
      smp_q.delete();
      mf = 3'b000; base = e;
      exp_h = 3'b000; exp_off = 3'b111; exp_fault = 1'b1; exp_serr = 1'b0;
      exp_per = '0; exp_pv = 1'b0; exp_stall = 1'b0; exp_rot = 1'b0;
    end else begin
      tab       = drive_tab(mf);
      exp_fault = (idx_of(mf) < 0);
      exp_off   = tab[2:0];
      exp_h     = dir ? ~(tab[5:3] | tab[2:0]) : tab[5:3];
      raw_q.push_back(hall);
      s = (raw_q.size() >= 3) ? raw_q[raw_q.size()-3] : 3'b000;
      if (raw_q.size() > 3) void'(raw_q.pop_front());
      smp_q.push_back(s);
      if (smp_q.size() > FL) void'(smp_q.pop_front());
      stable = (smp_q.size() == FL);
      foreach (smp_q[i]) if (smp_q[i] != s) stable = 1'b0;
      nf = stable ? s : mf;
      exp_pv = 1'b0;
      bad = 1'b0;
      if (nf != mf) begin
        oi = idx_of(mf);
        ni = idx_of(nf);
        if (oi >= 0 && ni >= 0) begin
          exp_pv  = 1'b1;
          exp_per = PW'((e - base > PMAX) ? PMAX : e - base);
          base    = e;
          d = (ni - oi + 6) % 6;
          if (d == 1)      exp_rot = 1'b0;
          else if (d == 5) exp_rot = 1'b1;
          else             bad = 1'b1;
        end
        mf = nf;
      end
      if (bad)            exp_serr = 1'b1;
      else if (fault_clr) exp_serr = 1'b0;
      exp_stall = (e - base >= PMAX);
    end
  end

  always @(posedge clock) begin
    #1;
    checks++;
    if (period_valid === 1'b1) pv_seen++;
    if ({h_phase, off_phase, fault, step_err, hall_period, period_valid, stalled, rot_dir} !==
        {exp_h, exp_off, exp_fault, exp_serr, exp_per, exp_pv, exp_stall, exp_rot}) begin
      errors++;
      $display("FAIL model_cmp @%0t: got h=%b off=%b flt=%b serr=%b per=%0d pv=%b stl=%b rot=%b, expected h=%b off=%b flt=%b serr=%b per=%0d pv=%b stl=%b rot=%b",
               $time, h_phase, off_phase, fault, step_err, hall_period, period_valid, stalled, rot_dir,
               exp_h, exp_off, exp_fault, exp_serr, exp_per, exp_pv, exp_stall, exp_rot);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    int p;
    cyc(3);
    chk("rst_h_phase", 32'(h_phase), 32'h0);
    chk("rst_off_phase", 32'(off_phase), 32'h7);
    chk("rst_fault", 32'(fault), 32'h1);
    chk("rst_step_err", 32'(step_err), 32'h0);
    chk("rst_period", 32'(hall_period), 32'h0);
    chk("rst_pv_stall_rot", 32'({period_valid, stalled, rot_dir}), 32'h0);
    reset = 1'b0;
    cyc(6);
    chk("latency_edge6_h", 32'(h_phase), 32'h0);
    cyc(1);
    chk("latency_edge7_h", 32'(h_phase), 32'h4);
    chk("latency_edge7_off", 32'(off_phase), 32'h1);
    chk("latency_edge7_fault", 32'(fault), 32'h0);
    dir = 1'b1;
    cyc(1);
    chk("rev_h", 32'(h_phase), 32'h2);
    chk("rev_off", 32'(off_phase), 32'h1);
    dir = 1'b0;
    cyc(1);
    chk("fwd_again_h", 32'(h_phase), 32'h4);

    hall = 3'b100; cyc(3); hall = 3'b101; cyc(12);
    chk("glitch_h", 32'(h_phase), 32'h4);
    chk("glitch_step_err", 32'(step_err), 32'h0);
    chk("glitch_no_pv", 32'(pv_seen), 32'd0);

    hall = 3'b100; cyc(100); hall = 3'b110; cyc(100);
    chk("fwd_period", 32'(hall_period), 32'd100);
    chk("fwd_rot", 32'(rot_dir), 32'h0);
    chk("fwd_pv_count", 32'(pv_seen), 32'd2);
    chk("fwd_h_110", 32'(h_phase), 32'h2);

    hall = 3'b100; cyc(100); hall = 3'b101; cyc(20);
    chk("revseq_rot", 32'(rot_dir), 32'h1);
    chk("revseq_period", 32'(hall_period), 32'd100);
    chk("revseq_pv_count", 32'(pv_seen), 32'd4);

    hall = 3'b110; cyc(20);
    chk("jump_step_err", 32'(step_err), 32'h1);
    chk("jump_rot_kept", 32'(rot_dir), 32'h1);
    cyc(20);
    chk("jump_sticky", 32'(step_err), 32'h1);
    fault_clr = 1'b1; cyc(1); fault_clr = 1'b0; cyc(1);
    chk("fault_clr", 32'(step_err), 32'h0);

    hall = 3'b010; cyc(300);
    chk("stall_set", 32'(stalled), 32'h1);
    chk("stall_rot", 32'(rot_dir), 32'h0);
    hall = 3'b011; cyc(20);
    chk("stall_clear", 32'(stalled), 32'h0);
    chk("stall_period", 32'(hall_period), 32'd255);

    hall = 3'b111; cyc(20);
    chk("f111_h", 32'(h_phase), 32'h0);
    chk("f111_off", 32'(off_phase), 32'h7);
    chk("f111_fault", 32'(fault), 32'h1);
    p = pv_seen;
    hall = 3'b011; cyc(20);
    chk("f111_ret_step_err", 32'(step_err), 32'h0);
    chk("f111_ret_no_pv", 32'(pv_seen), 32'(p));
    chk("f111_ret_h", 32'(h_phase), 32'h1);
    chk("f111_ret_off", 32'(off_phase), 32'h2);

    hall = 3'b001; cyc(2); reset = 1'b1; cyc(2); reset = 1'b0; cyc(20);
    chk("rst_mid_step_err", 32'(step_err), 32'h0);
    chk("rst_mid_period", 32'(hall_period), 32'h0);
    chk("rst_mid_no_pv", 32'(pv_seen), 32'(p));
    chk("rst_mid_h", 32'(h_phase), 32'h1);
    chk("rst_mid_off", 32'(off_phase), 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hall_commutator.md
HALL_COMMUTATOR -- requirements
Module: hall_commutator

Interface
REQ-001 Parameter FILTER_LEN, default 4, meaning consecutive identical synchronised samples needed to accept a hall state (range 1..255).
REQ-002 Parameter PERIOD_W, default 16, meaning width of the hall-period counter and output.
REQ-003 Port clock, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 Port hall, input, 3, meaning raw asynchronous hall inputs; hall[2] is hall 1, hall[0] is hall 3.
REQ-006 Port dir, input, 1, meaning drive direction; 0 is forward, 1 is reverse.
REQ-007 Port fault_clr, input, 1, meaning one-cycle pulse that clears sticky step_err.
REQ-008 Port h_phase, output, 3, meaning the phase driven high; bit 2 is phase A, bit 0 is phase C.
REQ-009 Port off_phase, output, 3, meaning the high-impedance phase(s).
REQ-010 Port fault, output, 1, meaning the accepted hall state is 000 or 111.
REQ-011 Port step_err, output, 1, meaning sticky flag for an illegal accepted transition.
REQ-012 Port hall_period, output, PERIOD_W, meaning clocks between the last two accepted valid-state changes.
REQ-013 Port period_valid, output, 1, meaning one-cycle strobe when hall_period updates.
REQ-014 Port stalled, output, 1, meaning no accepted change within 2^PERIOD_W-1 clocks.
REQ-015 Port rot_dir, output, 1, meaning measured rotation; 0 is forward sequence, 1 is reverse.

Function
REQ-016 The hall input SHALL pass through a 2-flop synchroniser before any other use.
REQ-017 The filter SHALL count consecutive identical synchronised samples and load the accepted state hall_f on the cycle the count reaches FILTER_LEN; any differing sample restarts the count at 1.
REQ-018 Commutation SHALL be registered from hall_f, one cycle after hall_f updates, using this table (hall: high/off): 101:100/001, 100:100/010, 110:010/100, 010:010/001, 011:001/010, 001:001/100.
REQ-019 When dir=1, h_phase SHALL be ~(high|off) and off_phase SHALL be unchanged, swapping the high and low phases; a dir change SHALL appear on the outputs on the next clock.
REQ-020 When hall_f is 000 or 111, h_phase SHALL be 000, off_phase 111 and fault 1; otherwise fault SHALL be 0.
REQ-021 The forward sequence index SHALL be 101=0, 100=1, 110=2, 010=3, 011=4, 001=5, wrapping 5->0.
REQ-022 On a change of hall_f between two valid states: an index delta of +1 mod 6 SHALL set rot_dir=0, a delta of -1 mod 6 SHALL set rot_dir=1, and any other delta SHALL set step_err and leave rot_dir unchanged.
REQ-023 A change into or out of a fault state SHALL NOT set step_err, update the period or change rot_dir.
REQ-024 step_err SHALL clear on fault_clr unless an illegal transition occurs in the same cycle; the set SHALL win.
REQ-025 The period counter SHALL increment every clock and saturate at 2^PERIOD_W-1.
REQ-026 On each valid-to-valid hall_f change, hall_period SHALL load the counter value +1 (saturating), period_valid SHALL pulse for 1 cycle, and the counter SHALL restart at 0.
REQ-027 stalled SHALL assert on the cycle the counter saturates and SHALL clear on the next valid-to-valid change.
REQ-028 Latency from a hall input change to h_phase SHALL be FILTER_LEN+3 clocks for input held stable.

Reset
REQ-029 During reset the block SHALL set h_phase=000, off_phase=111, fault=1, step_err=0, hall_period=0, period_valid=0, stalled=0, rot_dir=0, hall_f=000, the filter count to 0 and the period counter to 0.
REQ-030 Reset asserted mid-filter or mid-period SHALL discard all partial state; the first accepted state after reset SHALL NOT set step_err or update the period.

Verification
REQ-031 FILTER_LEN=4, hall held at 101 after reset -> h_phase=100, off_phase=001 and fault=0 exactly 7 clocks after the first edge; with dir=1, h_phase=010.
REQ-032 With hall at 101, a 3-clock glitch to 100 -> no output change and step_err=0.
REQ-033 Forward sequence 101->100->110 with 100 clocks per step -> rot_dir=0, period_valid pulses and hall_period=100; the reverse sequence gives rot_dir=1.
REQ-034 A jump 101->110 -> step_err=1 that persists; a fault_clr pulse then clears it.
REQ-035 PERIOD_W=8, hall held at 010 -> stalled=1 at counter value 255; the next legal step clears stalled and gives hall_period=255.
REQ-036 hall=111 accepted -> h_phase=000, off_phase=111, fault=1; returning to 011 gives no step_err and no period_valid.
